// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
// Fetch queue entry and fetch FSM states live here.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t npc;
    } fetch_entry_t;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Sequential successor address, wraps mod 2^32.
    function automatic word_t npc_of(input word_t a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode.
// Flush empties it; storage clears only on reset.
module fetch_queue
    import cpu_types_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wdata,
    output logic                         full,
    output logic                         empty,
    output fetch_entry_t                 head,
    output logic [$clog2(QDEPTH+1)-1:0]  count
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    fetch_entry_t    mem [QDEPTH];
    logic [AW-1:0]   rptr;
    logic [AW-1:0]   wptr;
    logic            wr;
    logic            rd;

    assign full  = (count == CW'(QDEPTH));
    assign empty = (count == '0);
    assign rd    = pop & ~empty & ~flush;
    assign wr    = push & (~full | rd) & ~flush;
    assign head  = mem[rptr];

    // Entry storage: written at the tail on an accepted push.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally since depth is a power of two.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            unique case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues icache reads, queues results for decode,
// steers the PC and handles redirect and halt.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc,
    output logic        pc_incr,
    output logic [31:0] pc_comb,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_npc,
    input  logic        decode_ready
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t   state;
    fetch_entry_t   head;
    fetch_entry_t   wdata;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic [CW-1:0]  count;

    assign iaddr       = pc;
    assign instr_valid = ~empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign instr_npc   = head.npc;

    assign pop   = instr_valid & decode_ready & ~redirect;
    assign iREN  = nRST & (state == FETCH) & ~halt & ~redirect
                 & (~full | pop);
    assign push  = iREN & ihit;
    assign wdata = '{instr: iload, pc: pc, npc: npc_of(pc)};

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (wdata),
        .full  (full),
        .empty (empty),
        .head  (head),
        .count (count)
    );

    // Next-PC select: redirect beats a completed fetch.
    always_comb begin
        pc_incr = 1'b0;
        pc_comb = pc;
        if (nRST) begin
            if (redirect) begin
                pc_incr = 1'b1;
                pc_comb = redirect_addr;
            end else if (push) begin
                pc_incr = 1'b1;
                pc_comb = npc_of(pc);
            end
        end
    end

    // Halt is sticky until reset; a same-cycle redirect wins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
        end else begin
            unique case (state)
                FETCH:   if (halt && !redirect) state <= HALTED;
                HALTED:  state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (QDEPTH=2).
// Bench owns a PC register model that loads pc_comb on pc_incr.
module tb_fetch_unit;

    logic        CLK;
    logic        nRST;
    logic [31:0] pc;
    logic        pc_incr;
    logic [31:0] pc_comb;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        halt;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_npc;
    logic        decode_ready;

    logic [31:0] pc_rst;
    int          checks;
    int          failures;

    fetch_unit #(.QDEPTH(2)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .pc            (pc),
        .pc_incr       (pc_incr),
        .pc_comb       (pc_comb),
        .iREN          (iREN),
        .iaddr         (iaddr),
        .ihit          (ihit),
        .iload         (iload),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_npc     (instr_npc),
        .decode_ready  (decode_ready)
    );

    always #5 CLK = ~CLK;

    // Program counter register model.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) pc <= pc_rst;
        else if (pc_incr) pc <= pc_comb;
    end

    task automatic idle_inputs();
        ihit = 0; iload = 0; redirect = 0; redirect_addr = 0;
        halt = 0; decode_ready = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 with nRST high.
    task automatic apply_reset(input logic [31:0] v);
        idle_inputs();
        pc_rst = v;
        nRST = 0;
        @(posedge CLK); #1;
        nRST = 1;
    endtask

    task automatic next_cycle();
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        pc_rst = 32'h0;
        nRST = 0;
        ihit = 1; decode_ready = 1; iload = 32'hFFFF_FFFF;
        @(negedge CLK);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
        checks++; if (instr_npc !== 32'h0) begin failures++; $display("FAIL rst_instr_npc got=%h exp=0", instr_npc); end
        checks++; if (iREN !== 1'b0) begin failures++; $display("FAIL rst_iren got=%b exp=0", iREN); end
        checks++; if (pc_incr !== 1'b0) begin failures++; $display("FAIL rst_pc_incr got=%b exp=0", pc_incr); end
        redirect = 1; redirect_addr = 32'h80;
        #1;
        checks++; if (pc_incr !== 1'b0) begin failures++; $display("FAIL rst_redir_pc_incr got=%b exp=0", pc_incr); end
        @(posedge CLK); #1;
        idle_inputs();
        nRST = 1;
    endtask

    task automatic test_stream();
        apply_reset(32'h0);
        ihit = 1; decode_ready = 1;
        for (int k = 0; k < 4; k++) begin
            iload = 32'h1000 + k;
            @(negedge CLK);
            checks++; if (pc_incr !== 1'b1) begin failures++; $display("FAIL stream_pc_incr k=%0d got=%b exp=1", k, pc_incr); end
            checks++; if (pc_comb !== 32'(4 * (k + 1))) begin failures++; $display("FAIL stream_pc_comb k=%0d got=%h exp=%h", k, pc_comb, 4 * (k + 1)); end
            checks++; if (iaddr !== 32'(4 * k)) begin failures++; $display("FAIL stream_iaddr k=%0d got=%h exp=%h", k, iaddr, 4 * k); end
            if (k == 0) begin
                checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_first_valid got=%b exp=0", instr_valid); end
            end else begin
                checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, instr_valid); end
                checks++; if (instr_pc !== 32'(4 * (k - 1))) begin failures++; $display("FAIL stream_instr_pc k=%0d got=%h exp=%h", k, instr_pc, 4 * (k - 1)); end
                checks++; if (instr !== 32'h1000 + 32'(k - 1)) begin failures++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, instr, 32'h1000 + k - 1); end
            end
            next_cycle();
        end
        ihit = 0;
        @(negedge CLK);
        checks++; if (pc_incr !== 1'b0) begin failures++; $display("FAIL stream_nohit_incr got=%b exp=0", pc_incr); end
        checks++; if (pc_comb !== 32'h10) begin failures++; $display("FAIL stream_nohit_comb got=%h exp=00000010", pc_comb); end
        checks++; if (instr_pc !== 32'hC) begin failures++; $display("FAIL stream_last_pc got=%h exp=0000000c", instr_pc); end
        next_cycle();
        @(negedge CLK);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_drained got=%b exp=0", instr_valid); end
        next_cycle();
    endtask

    task automatic test_full();
        apply_reset(32'h0);
        ihit = 1; decode_ready = 0;
        iload = 32'h2000; next_cycle();
        iload = 32'h2001; next_cycle();
        iload = 32'h2002;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            checks++; if (iREN !== 1'b0) begin failures++; $display("FAIL full_iren k=%0d got=%b exp=0", k, iREN); end
            checks++; if (pc_incr !== 1'b0) begin failures++; $display("FAIL full_pc_incr k=%0d got=%b exp=0", k, pc_incr); end
            checks++; if (pc_comb !== 32'h8) begin failures++; $display("FAIL full_pc_comb k=%0d got=%h exp=00000008", k, pc_comb); end
            checks++; if (dut.u_queue.count !== 2'd2) begin failures++; $display("FAIL full_count k=%0d got=%0d exp=2", k, dut.u_queue.count); end
            checks++; if (instr_pc !== 32'h0 || instr !== 32'h2000) begin failures++; $display("FAIL full_hold k=%0d got=%h/%h exp=00000000/00002000", k, instr_pc, instr); end
            next_cycle();
        end
        decode_ready = 1;
        @(negedge CLK);
        checks++; if (iREN !== 1'b1) begin failures++; $display("FAIL full_pop_iren got=%b exp=1", iREN); end
        checks++; if (pc_comb !== 32'hC) begin failures++; $display("FAIL full_pop_comb got=%h exp=0000000c", pc_comb); end
        next_cycle();
        decode_ready = 0;
        @(negedge CLK);
        checks++; if (dut.u_queue.count !== 2'd2) begin failures++; $display("FAIL full_swap_count got=%0d exp=2", dut.u_queue.count); end
        checks++; if (instr_pc !== 32'h4 || instr !== 32'h2001) begin failures++; $display("FAIL full_swap_head got=%h/%h exp=00000004/00002001", instr_pc, instr); end
        checks++; if (iREN !== 1'b0) begin failures++; $display("FAIL full_swap_iren got=%b exp=0", iREN); end
        next_cycle();
    endtask

    task automatic test_redirect();
        apply_reset(32'h0);
        ihit = 1; decode_ready = 0;
        iload = 32'h3000; next_cycle();
        iload = 32'h3001; next_cycle();
        redirect = 1; redirect_addr = 32'h100; iload = 32'hDEAD;
        @(negedge CLK);
        checks++; if (pc_incr !== 1'b1) begin failures++; $display("FAIL redir_pc_incr got=%b exp=1", pc_incr); end
        checks++; if (pc_comb !== 32'h100) begin failures++; $display("FAIL redir_pc_comb got=%h exp=00000100", pc_comb); end
        checks++; if (iREN !== 1'b0) begin failures++; $display("FAIL redir_iren got=%b exp=0", iREN); end
        next_cycle();
        redirect = 0; ihit = 0;
        @(negedge CLK);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_empty got=%b exp=0", instr_valid); end
        checks++; if (iaddr !== 32'h100) begin failures++; $display("FAIL redir_iaddr got=%h exp=00000100", iaddr); end
        next_cycle();
        ihit = 1; iload = 32'h3100; decode_ready = 1;
        next_cycle();
        ihit = 0;
        @(negedge CLK);
        checks++; if (instr !== 32'h3100 || instr_pc !== 32'h100) begin failures++; $display("FAIL redir_refetch got=%h/%h exp=00003100/00000100", instr, instr_pc); end
        next_cycle();
    endtask

    task automatic test_halt();
        apply_reset(32'h0);
        ihit = 1; decode_ready = 0;
        iload = 32'h5000; next_cycle();
        iload = 32'h5001; next_cycle();
        halt = 1;
        @(negedge CLK);
        checks++; if (iREN !== 1'b0 || pc_incr !== 1'b0) begin failures++; $display("FAIL halt_cycle got=%b/%b exp=0/0", iREN, pc_incr); end
        next_cycle();
        halt = 0; decode_ready = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            checks++; if (iREN !== 1'b0) begin failures++; $display("FAIL halt_iren k=%0d got=%b exp=0", k, iREN); end
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k)) begin failures++; $display("FAIL halt_drain k=%0d got=%b/%h exp=1/%h", k, instr_valid, instr_pc, 4 * k); end
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checks++; if (instr_valid !== 1'b0 || iREN !== 1'b0 || pc_incr !== 1'b0) begin failures++; $display("FAIL halt_idle k=%0d got=%b/%b/%b exp=0/0/0", k, instr_valid, iREN, pc_incr); end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(32'h40);
        ihit = 1; decode_ready = 0;
        iload = 32'h6000; next_cycle();
        iload = 32'h6001; next_cycle();
        nRST = 0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", instr_valid); end
        checks++; if (dut.u_queue.count !== 2'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", dut.u_queue.count); end
        checks++; if (iREN !== 1'b0 || pc_incr !== 1'b0) begin failures++; $display("FAIL rmid_idle got=%b/%b exp=0/0", iREN, pc_incr); end
        @(posedge CLK); #1;
        nRST = 1; iload = 32'h6100; decode_ready = 1;
        @(negedge CLK);
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin failures++; $display("FAIL rmid_resume got=%b/%h exp=1/00000040", iREN, iaddr); end
        checks++; if (pc_comb !== 32'h44) begin failures++; $display("FAIL rmid_pc_comb got=%h exp=00000044", pc_comb); end
        next_cycle();
        ihit = 0;
        @(negedge CLK);
        checks++; if (instr !== 32'h6100 || instr_pc !== 32'h40) begin failures++; $display("FAIL rmid_head got=%h/%h exp=00006100/00000040", instr, instr_pc); end
        next_cycle();
    endtask

    task automatic test_wrap();
        apply_reset(32'hFFFF_FFFC);
        ihit = 1; iload = 32'h7000; decode_ready = 1;
        @(negedge CLK);
        checks++; if (pc_comb !== 32'h0 || pc_incr !== 1'b1) begin failures++; $display("FAIL wrap_pc_comb got=%h/%b exp=00000000/1", pc_comb, pc_incr); end
        next_cycle();
        ihit = 0;
        @(negedge CLK);
        checks++; if (instr_npc !== 32'h0) begin failures++; $display("FAIL wrap_npc got=%h exp=00000000", instr_npc); end
        checks++; if (instr_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_instr_pc got=%h exp=fffffffc", instr_pc); end
        checks++; if (iaddr !== 32'h0) begin failures++; $display("FAIL wrap_iaddr got=%h exp=00000000", iaddr); end
        next_cycle();
    endtask

    initial begin
        CLK = 0;
        checks = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_halt();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
